// File: rtl/btn_debounce_repeat.sv
// Per-channel button conditioner: 2-FF sync, debounce FSM, press pulse plus optional hold-to-repeat (macro BTN_AUTOREPEAT_EN).
// Latency: press pulse DEB_CYCLES+2 clk after raw is first sampled; outputs registered.
// Backpressure: none; ena=0 freezes FSM/timers and drops any pulse due on that cycle.
module btn_debounce_repeat #(
    parameter int CHANNELS     = 3,
    parameter int TMR_W        = 20,
    parameter int DEB_CYCLES   = 10000,
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_RATE  = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_pulse,
    output logic [CHANNELS-1:0] btn_held
);

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
`else
    localparam bit AUTOREPEAT = 1'b0;
`endif

    localparam logic [TMR_W-1:0] DEB_LAST   = TMR_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HOLD,
        REPEAT,
        DEB_RELEASE
    } state_t;

    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] t);
        return (t == '1) ? t : t + TMR_W'(1);
    endfunction

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t           state_q;
        logic [TMR_W-1:0] timer_q;
        logic             drop_q;
        logic             level_q;
        logic             pulse_q;
        logic             held_q;
        logic             due;
        logic             sync;

        assign sync = sync2_q[g];

        // A pulse-emitting transition is due this cycle
        always_comb begin
            due = 1'b0;
            case (state_q)
                DEB_PRESS: due = sync && (timer_q == DEB_LAST);
                HOLD:      due = AUTOREPEAT && sync && (timer_q == DELAY_LAST);
                REPEAT:    due = sync && (timer_q == RATE_LAST);
                default:   due = 1'b0;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                timer_q <= '0;
                drop_q  <= 1'b0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                if (!ena) begin
                    // Remember that a pulse was due while frozen so it is discarded, not replayed
                    drop_q <= due;
                end else begin
                    drop_q <= 1'b0;
                    case (state_q)
                        IDLE: begin
                            if (sync) begin
                                state_q <= DEB_PRESS;
                                timer_q <= '0;
                            end
                        end
                        DEB_PRESS: begin
                            if (!sync) begin
                                state_q <= IDLE;
                            end else if (due) begin
                                state_q <= HOLD;
                                timer_q <= '0;
                                level_q <= 1'b1;
                                held_q  <= 1'b1;
                                pulse_q <= !drop_q;
                            end else begin
                                timer_q <= tmr_inc(timer_q);
                            end
                        end
                        HOLD, REPEAT: begin
                            if (!sync) begin
                                state_q <= DEB_RELEASE;
                                timer_q <= '0;
                                held_q  <= 1'b0;
                            end else if (due) begin
                                state_q <= REPEAT;
                                timer_q <= '0;
                                pulse_q <= !drop_q;
                            end else begin
                                timer_q <= tmr_inc(timer_q);
                            end
                        end
                        DEB_RELEASE: begin
                            if (sync) begin
                                state_q <= HOLD;
                                timer_q <= '0;
                                held_q  <= 1'b1;
                            end else if (timer_q == DEB_LAST) begin
                                state_q <= IDLE;
                                level_q <= 1'b0;
                            end else begin
                                timer_q <= tmr_inc(timer_q);
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end

        assign btn_level[g] = level_q;
        assign btn_pulse[g] = pulse_q;
        assign btn_held[g]  = held_q;
    end

endmodule
